// File: rtl/uart_pkg.sv
// Shared UART constants and state encodings for the receive path.
package uart_pkg;

  localparam int CLKS_PER_BIT_9600_100M = 10416;
  localparam int UART_DATA_BITS         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    PHASE_HIGH = 1'b0,
    PHASE_LOW  = 1'b1
  } byte_phase_t;

endpackage

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 2-FF synchroniser, baud counter and bit-level FSM.
// Emits one-cycle VALID or FRAME_ERR pulses at the stop-bit sample point.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_9600_100M
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'(uart_pkg::UART_DATA_BITS - 1);

  logic                rx_meta_q, rx_sync_q;
  uart_pkg::rx_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;

  // Next-state logic; every decision uses the synchronised line value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      uart_pkg::IDLE: begin
        cnt_d = CNT_ZERO;
        bit_d = 3'd0;
        if (!rx_sync_q) state_d = uart_pkg::START;
        else            state_d = uart_pkg::IDLE;
      end
      uart_pkg::START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = CNT_ZERO;
          // A line that is high again at mid start bit was only a glitch
          if (rx_sync_q) state_d = uart_pkg::IDLE;
          else           state_d = uart_pkg::DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      uart_pkg::DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = uart_pkg::STOP;
          else                   state_d = uart_pkg::DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      uart_pkg::STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = uart_pkg::IDLE;
          valid_d = rx_sync_q;
          ferr_d  = ~rx_sync_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = uart_pkg::IDLE;
        cnt_d   = CNT_ZERO;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Synchroniser and receiver state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= uart_pkg::IDLE;
      cnt_q     <= CNT_ZERO;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign DATA      = shift_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: rtl/uart_rx_to_ram.sv
// Receives UART bytes, packs pairs high-byte-first into 16-bit words and
// writes them to RAM addresses 0..NUM_WORDS-1 once, then holds done high.
module uart_rx_to_ram
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_100M,
  parameter int NUM_WORDS    = 64,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_RX,
  output logic              write_enable_to_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic [15:0]       data_to_ram,
  output logic              frame_error,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [7:0]        byte_s;
  logic              byte_valid_s;
  logic              ferr_s;

  byte_phase_t       phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              we_q, we_d;
  logic              done_q, done_d;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_ctrl (
    .clk      (clk),
    .reset    (reset),
    .RX       (uart_RX),
    .DATA     (byte_s),
    .VALID    (byte_valid_s),
    .FRAME_ERR(ferr_s)
  );

  // Word packing, write strobe, address advance and completion
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = done_q;
    if (byte_valid_s && !done_q) begin
      if (phase_q == PHASE_HIGH) begin
        hi_d    = byte_s;
        phase_d = PHASE_LOW;
      end else begin
        data_d  = {hi_q, byte_s};
        we_d    = 1'b1;
        phase_d = PHASE_HIGH;
      end
    end else begin
      phase_d = phase_q;
    end
    // Address moves only after the strobe so it is stable during the write
    if (we_q) begin
      if (addr_q == ADDR_LAST) done_d = 1'b1;
      else                     addr_d = addr_q + ADDR_ONE;
    end else begin
      addr_d = addr_q;
    end
  end

  // Word assembly registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PHASE_HIGH;
      hi_q    <= 8'h00;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= 16'h0000;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign write_enable_to_ram = we_q;
  assign address_to_ram      = addr_q;
  assign data_to_ram         = data_q;
  assign frame_error         = ferr_s;
  assign done                = done_q;

endmodule

// File: tb/tb_uart_rx_to_ram.sv
// Scenario bench for uart_rx_to_ram: expected writes are queued as bytes are
// sent and matched against each observed write strobe.
module tb_uart_rx_to_ram;

  localparam int CPB = 16;
  localparam int NW  = 4;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          we;
  logic [AW-1:0] addr;
  logic [15:0]   data;
  logic          ferr;
  logic          done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_wr = 0;
  int ferr_cnt = 0;
  int last_wr_cyc = -1;
  int done_rise_cyc = -1;
  logic done_prev = 1'b0;
  logic [AW+15:0] exp_q[$];

  uart_rx_to_ram #(
    .CLKS_PER_BIT(CPB),
    .NUM_WORDS   (NW),
    .ADDR_W      (AW)
  ) dut (
    .clk                (clk),
    .reset              (rst_n),
    .uart_RX            (rx),
    .write_enable_to_ram(we),
    .address_to_ram     (addr),
    .data_to_ram        (data),
    .frame_error        (ferr),
    .done               (done)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe pops and checks the oldest expected write
  always @(negedge clk) begin
    logic [AW+15:0] e;
    cyc = cyc + 1;
    if (we === 1'b1) begin
      n_wr = n_wr + 1;
      last_wr_cyc = cyc;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_write got addr=%0d data=%h required no write", addr, data);
      end else begin
        e = exp_q.pop_front();
        if ({addr, data} !== e) begin
          failures = failures + 1;
          $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                   addr, data, e[AW+15:16], e[15:0]);
        end
      end
    end
    if (ferr === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic push_exp(input int a, input logic [15:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    n_wr = 0;
    ferr_cnt = 0;
    last_wr_cyc = -1;
    done_rise_cyc = -1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({we, addr, data, ferr, done} !== '0) begin
      failures++;
      $display("FAIL reset_values got we=%b addr=%0d data=%h ferr=%b done=%b required all 0",
               we, addr, data, ferr, done);
    end
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    checks++;
    if (n_wr != 0 || {we, addr, data, ferr, done} !== '0) begin
      failures++;
      $display("FAIL idle_quiet got writes=%0d addr=%0d data=%h done=%b required 0 writes, all 0",
               n_wr, addr, data, done);
    end
  endtask

  task automatic test_pairs();
    do_reset();
    push_exp(0, 16'hABCD);
    push_exp(1, 16'h1234);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    drain();
    checks++;
    if (n_wr != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL pairs_count got writes=%0d pending=%0d required 2 and 0", n_wr, exp_q.size());
    end
    checks++;
    if (addr !== AW'(2) || ferr_cnt != 0) begin
      failures++;
      $display("FAIL pairs_addr got addr=%0d ferr=%0d required 2 and 0", addr, ferr_cnt);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (n_wr != 0 || ferr_cnt != 0) begin
      failures++;
      $display("FAIL glitch_quiet got writes=%0d ferr=%0d required 0 and 0", n_wr, ferr_cnt);
    end
    push_exp(0, 16'h55AA);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    drain();
    checks++;
    if (n_wr != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL glitch_count got writes=%0d pending=%0d required 1 and 0", n_wr, exp_q.size());
    end
  endtask

  task automatic test_frame_error();
    do_reset();
    send_byte(8'h11, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (ferr_cnt != 1 || n_wr != 0) begin
      failures++;
      $display("FAIL ferr_pulse got pulses=%0d writes=%0d required 1 and 0", ferr_cnt, n_wr);
    end
    push_exp(0, 16'h2233);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    drain();
    checks++;
    if (n_wr != 1 || exp_q.size() != 0 || ferr_cnt != 1 || addr !== AW'(1)) begin
      failures++;
      $display("FAIL ferr_after got writes=%0d pending=%0d ferr=%0d addr=%0d required 1,0,1,1",
               n_wr, exp_q.size(), ferr_cnt, addr);
    end
  endtask

  task automatic test_done();
    do_reset();
    for (int k = 0; k < NW; k++) push_exp(k, {8'(2 * k), 8'(2 * k + 1)});
    for (int b = 0; b < 6; b++) send_byte(8'(b), 1'b1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_early got done=%b required 0", done);
    end
    for (int b = 6; b < 10; b++) send_byte(8'(b), 1'b1);
    drain();
    checks++;
    if (n_wr != NW || exp_q.size() != 0) begin
      failures++;
      $display("FAIL done_count got writes=%0d pending=%0d required %0d and 0", n_wr, exp_q.size(), NW);
    end
    checks++;
    if (done !== 1'b1 || done_rise_cyc != last_wr_cyc + 1) begin
      failures++;
      $display("FAIL done_timing got done=%b rise=%0d last_strobe=%0d required 1 and rise=strobe+1",
               done, done_rise_cyc, last_wr_cyc);
    end
    checks++;
    if (addr !== AW'(NW - 1)) begin
      failures++;
      $display("FAIL done_addr got addr=%0d required %0d", addr, NW - 1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_exp(0, 16'hDEAD);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    drain();
    checks++;
    if (data !== 16'hDEAD || addr !== AW'(1)) begin
      failures++;
      $display("FAIL mid_pre got addr=%0d data=%h required 1 and dead", addr, data);
    end
    send_byte(8'h10, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({we, addr, data, ferr, done} !== '0) begin
      failures++;
      $display("FAIL async_clear got we=%b addr=%0d data=%h ferr=%b done=%b required all 0",
               we, addr, data, ferr, done);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_wr = 0;
    exp_q.delete();
    push_exp(0, 16'h7788);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    drain();
    checks++;
    if (n_wr != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_after got writes=%0d pending=%0d required 1 and 0", n_wr, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    test_reset();
    test_pairs();
    test_glitch();
    test_frame_error();
    test_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
